// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states and ACK/NACK bus levels.
// Also imported by the I2C master so both ends agree on these values.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } i2c_state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_slave_if.sv
// Bus pins and fabric-side byte handshake of the I2C target.
interface i2c_slave_if;
  logic       SCL_IN;
  logic       SDA_IN;
  logic       SDA_OE;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic [7:0] TX_DATA;
  logic       TX_REQ;
  logic       BUSY;

  modport slave (
    input  SCL_IN, SDA_IN, TX_DATA,
    output SDA_OE, RX_DATA, RX_VALID, TX_REQ, BUSY
  );

  modport master (
    output SCL_IN, SDA_IN, TX_DATA,
    input  SDA_OE, RX_DATA, RX_VALID, TX_REQ, BUSY
  );
endinterface

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchronizer for one asynchronous bus line plus rise/fall detect.
// Flops reset to 1 (idle bus level) so reset never fabricates an edge.
module i2c_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: address match + ACK, byte delivery on writes, byte fetch on reads.
// SDA is open-drain; every SDA_OE change happens on a synchronized SCL fall.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h19,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  i2c_slave_if.slave  bus
);

  logic w_scl, w_scl_rise, w_scl_fall;
  logic w_sda, w_sda_rise, w_sda_fall;
  logic w_start, w_stop;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl (
    .CLK(CLK), .RST_N(RST_N), .i_async(bus.SCL_IN),
    .o_level(w_scl), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
  );

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
    .CLK(CLK), .RST_N(RST_N), .i_async(bus.SDA_IN),
    .o_level(w_sda), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
  );

  assign w_start = w_sda_fall & w_scl;
  assign w_stop  = w_sda_rise & w_scl;

  i2c_state_t r_state;
  logic [2:0] r_cnt;
  logic [7:0] r_shift;
  logic [6:0] r_tx;
  logic       r_rw;
  logic       r_phase;
  logic       r_mack;
  logic       r_sda_oe;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_tx_req;
  logic       r_busy;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state    <= IDLE;
      r_cnt      <= 3'd0;
      r_shift    <= 8'h00;
      r_tx       <= 7'h00;
      r_rw       <= 1'b0;
      r_phase    <= 1'b0;
      r_mack     <= I2C_NACK;
      r_sda_oe   <= 1'b0;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_tx_req   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_tx_req   <= 1'b0;
      if (w_stop) begin
        r_state  <= IDLE;
        r_sda_oe <= 1'b0;
        r_busy   <= 1'b0;
        r_cnt    <= 3'd0;
      end else if (w_start) begin
        r_state  <= ADDR;
        r_sda_oe <= 1'b0;
        r_cnt    <= 3'd0;
      end else begin
        case (r_state)
          ADDR: if (w_scl_rise) begin
            r_shift <= {r_shift[6:0], w_sda};
            r_cnt   <= r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
              r_rw    <= w_sda;
              r_phase <= 1'b0;
              if (r_shift[6:0] == SLAVE_ADDR) begin
                r_state <= ADDR_ACK;
                r_busy  <= 1'b1;
              end else begin
                r_state <= WAIT_STOP;
                r_busy  <= 1'b0;
              end
            end
          end
          // r_phase distinguishes the fall that opens the ACK from the one that closes it
          ADDR_ACK: if (w_scl_fall) begin
            if (!r_phase) begin
              r_sda_oe <= ~I2C_ACK;
              r_phase  <= 1'b1;
            end else if (r_rw) begin
              r_tx     <= bus.TX_DATA[6:0];
              r_sda_oe <= ~bus.TX_DATA[7];
              r_tx_req <= 1'b1;
              r_state  <= RD_DATA;
            end else begin
              r_sda_oe <= 1'b0;
              r_state  <= WR_DATA;
            end
          end
          WR_DATA: if (w_scl_rise) begin
            r_shift <= {r_shift[6:0], w_sda};
            r_cnt   <= r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
              r_state <= WR_ACK;
              r_phase <= 1'b0;
            end
          end
          WR_ACK: if (w_scl_fall) begin
            if (!r_phase) begin
              r_sda_oe   <= ~I2C_ACK;
              r_phase    <= 1'b1;
              r_rx_data  <= r_shift;
              r_rx_valid <= 1'b1;
            end else begin
              r_sda_oe <= 1'b0;
              r_state  <= WR_DATA;
            end
          end
          RD_DATA: if (w_scl_rise) begin
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
              r_state <= RD_ACK;
              r_phase <= 1'b0;
            end
          end else if (w_scl_fall) begin
            r_sda_oe <= ~r_tx[6];
            r_tx     <= {r_tx[5:0], 1'b0};
          end
          // First fall hands SDA back, the rise samples the master, the second fall acts on it
          RD_ACK: if (w_scl_rise) begin
            r_mack  <= w_sda;
            r_phase <= 1'b1;
          end else if (w_scl_fall) begin
            if (!r_phase) begin
              r_sda_oe <= 1'b0;
            end else if (r_mack == I2C_NACK) begin
              r_sda_oe <= 1'b0;
              r_busy   <= 1'b0;
              r_state  <= WAIT_STOP;
            end else begin
              r_tx     <= bus.TX_DATA[6:0];
              r_sda_oe <= ~bus.TX_DATA[7];
              r_tx_req <= 1'b1;
              r_state  <= RD_DATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.SDA_OE   = r_sda_oe;
  assign bus.RX_DATA  = r_rx_data;
  assign bus.RX_VALID = r_rx_valid;
  assign bus.TX_REQ   = r_tx_req;
  assign bus.BUSY     = r_busy;

endmodule
